// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
// Shared definitions for the bit-serial adder sequencer:
//   - state_t : FSM state encodings (IDLE=0, RUN=1, DONE=2)
//   - sa_clog2: ceiling log2, used to size the bit counter
// Optional feature macro used elsewhere in this slice: SERIAL_ADD_SUB_EN
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2; callers guarantee value >= 2 so the result is >= 1.
    function automatic int sa_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Start/result bundle between the arithmetic harness (master) and the
// bit-serial adder sequencer (slave).
//   start  : request, accepted only while ready=1
//   a, b   : WIDTH-bit operands, sampled on the accepting edge
//   cin    : carry-in, sampled on the accepting edge
//   sub    : subtract select (only with SERIAL_ADD_SUB_EN defined)
//   ready  : sequencer idle
//   busy   : sequencer stepping the 1-bit cell
//   done   : one-cycle result-valid pulse
//   sum    : WIDTH-bit result, valid from done until the next accepted start
//   cout   : final carry (no-borrow flag when subtracting)
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output start, a, b, cin, sub,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin, sub,
        output ready, busy, done, sum, cout
    );
`else
    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout
    );
`endif

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl_fa_bit.sv
// -----------------------------------------------------------------------------
// serial_fa_bit
// Combinational single-bit full adder built only from 2/3-input NAND gates,
// matching the gate-level cell the sequencer drives.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : a_i ^ b_i ^ c_i (two NAND-XOR stages)
//   c_o      : majority(a_i, b_i, c_i) (NAND-NAND)
// -----------------------------------------------------------------------------
module serial_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // First XOR stage: p = a ^ b, four NANDs.
    logic n1_ab;
    logic n2_a;
    logic n3_b;
    logic p;

    assign n1_ab = ~(a_i & b_i);
    assign n2_a  = ~(a_i & n1_ab);
    assign n3_b  = ~(b_i & n1_ab);
    assign p     = ~(n2_a & n3_b);

    // Second XOR stage: s = p ^ c, four NANDs.
    logic n1_pc;
    logic n2_p;
    logic n3_c;

    assign n1_pc = ~(p & c_i);
    assign n2_p  = ~(p & n1_pc);
    assign n3_c  = ~(c_i & n1_pc);
    assign s_o   = ~(n2_p & n3_c);

    // Majority: NAND of the three pairwise NANDs.
    logic n_ac;
    logic n_bc;

    assign n_ac = ~(a_i & c_i);
    assign n_bc = ~(b_i & c_i);
    assign c_o  = ~(n1_ab & n_ac & n_bc);

endmodule : serial_fa_bit

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Sequencer for a bit-serial ripple adder: accepts a WIDTH-bit operand pair,
// steps one serial_fa_bit cell through the bits LSB first (one per clock),
// then presents sum/cout with a one-cycle done pulse.
//   Parameter WIDTH : operand/result width, 2..32 (default 8)
//   clk             : rising-edge clock
//   rst             : synchronous active-high reset
//   bus (slave)     : start/a/b/cin[/sub] in, ready/busy/done/sum/cout out
// Latency: accept at edge 0, busy in cycles 1..WIDTH, done in WIDTH+1,
// ready again in WIDTH+2.
// Optional feature: SERIAL_ADD_SUB_EN adds bus.sub; sub=1 computes a-b by
// loading ~b and a carry of 1 (cin ignored, cout=1 means no borrow).
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);

    localparam int             CNT_W    = sa_clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q,    sa_d;
    logic [WIDTH-1:0]   sb_q,    sb_d;
    logic [WIDTH-1:0]   res_q,   res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ready_q, ready_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic               fa_s;
    logic               fa_c;

    // Operand B and initial carry as loaded on the accepting edge.
    logic [WIDTH-1:0]   load_b;
    logic               load_c;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign load_b = bus.sub ? ~bus.b : bus.b;
    assign load_c = bus.sub ? 1'b1   : bus.cin;
`else
    assign load_b = bus.b;
    assign load_c = bus.cin;
`endif

    serial_fa_bit u_fa (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it
        // unassigned; otherwise a latch is inferred.
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = load_b;
                    carry_d = load_c;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB and walk down, so after WIDTH
                // steps the first (LSB) sum bit sits at bit 0.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered: decode them from the next state so
        // they line up with the state register.
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = res_q;
    assign bus.cout  = carry_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed self-checking bench for serial_add_ctrl (WIDTH=8). Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// With SERIAL_ADD_SUB_EN defined, the subtract vectors are exercised too.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;

    int checks;
    int errors;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE and check latency, result and hold.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub,
                          input logic [7:0] exp_sum, input logic exp_cout);
        int n;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = sub;
`else
        if (sub) $display("note: sub ignored in add-only build");
`endif
        bus.start = 1'b1;
        tick();                  // cycle 1
        bus.start = 1'b0;
        check({tag, "_busy1"}, 32'(bus.busy), 32'd1);
        n = 1;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(WIDTH + 1));
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        tick();                  // cycle WIDTH+2
        check({tag, "_ready"}, 32'(bus.ready), 32'd1);
        check({tag, "_hold"}, 32'({bus.cout, bus.sum}), 32'({exp_cout, exp_sum}));
    endtask

    initial begin
        int n;
        int busy_cycles;
        int done_seen;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_sum",   32'(bus.sum),   32'd0);
        check("rst_cout",  32'(bus.cout),  32'd0);
        rst = 1'b0;
        tick();

        // Basic additions
        run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("add80_80c", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);

        // start held high throughout; operands change during RUN
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        tick();                  // cycle 1
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
        busy_cycles = 0;
        n = 1;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_cycles++;
            tick();
            n++;
        end
        check("hold_busy_cycles", 32'(busy_cycles), 32'(WIDTH));
        check("hold_sum",  32'(bus.sum),  32'h46);
        check("hold_cout", 32'(bus.cout), 32'd0);
        check("hold_done_nobusy", 32'(bus.busy), 32'd0);
        tick();                  // cycle WIDTH+2
        check("hold_ready", 32'(bus.ready), 32'd1);
        bus.start = 1'b0;
        tick();
        check("hold_no_restart", 32'(bus.busy), 32'd0);

        // Reset in the 4th busy cycle
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        tick();                  // busy cycle 1
        bus.start = 1'b0;
        tick();
        tick();
        tick();                  // busy cycle 4
        check("abort_busy4", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_busy",  32'(bus.busy),  32'd0);
        check("abort_sum",   32'(bus.sum),   32'd0);
        check("abort_cout",  32'(bus.cout),  32'd0);
        done_seen = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            if (bus.done) done_seen++;
            tick();
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_op("add01_02", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

        // rst and start on the same edge
        bus.a     = 8'h0F;
        bus.b     = 8'h0F;
        bus.start = 1'b1;
        rst       = 1'b1;
        tick();
        bus.start = 1'b0;
        rst       = 1'b0;
        check("rststart_ready", 32'(bus.ready), 32'd1);
        check("rststart_busy",  32'(bus.busy),  32'd0);
        tick();
        check("rststart_busy2", 32'(bus.busy),  32'd0);

`ifdef SERIAL_ADD_SUB_EN
        // Subtraction; cin deliberately set to 0 to show it is ignored
        run_op("sub10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
        run_op("sub0_add", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_add_ctrl
